ahb_mem_slave: RTL and testbench

- AHB slave memory that sits directly downstream of the DMAC master port; serves the DMAC's source reads and destination writes (0x3800_1000 / 0x3800_2000 region).
- Single-port byte-addressable RAM with configurable wait states and a two-cycle ERROR response for illegal accesses.
- Drives HRDATA/HREADY/HRESP back to the DMAC master inputs.

---
 rtl/ahb_pkg.sv | 38 +++
 rtl/ahb_mem_ram.sv | 22 ++
 rtl/ahb_mem_slave.sv | 136 +++++++++++++
 tb/tb_ahb_mem_slave.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB codes, slave state encoding and byte-lane helper.
// Used by ahb_mem_slave (optional wait states via AHB_MEM_WAIT_EN).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    function automatic logic [3:0] byte_en(input logic [2:0] size,
                                           input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_mem_ram.sv
// Word-organised RAM with per-byte write enable and asynchronous read.
module ahb_mem_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic [MEM_AW-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: decode, legality check, FSM and RAM.
// Define AHB_MEM_WAIT_EN to insert WAIT_STATES wait cycles per OKAY transfer.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
    parameter int          MEM_AW      = 12,
    parameter int          WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [31:0] REGION = 32'd4 << MEM_AW;

`ifdef AHB_MEM_WAIT_EN
    localparam state_t LEGAL_ST = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
`else
    localparam state_t LEGAL_ST = ST_DATA;
`endif

    state_t            state;
    state_t            state_nx;
    logic [MEM_AW+1:0] a_addr;
    logic              a_write;
    logic [2:0]        a_size;
    logic [31:0]       offset;
    logic              aligned;
    logic              legal;
    logic              open;
    logic              accept;
    logic [3:0]        we;
    logic [31:0]       rdata;
    logic              unused_burst;

    assign unused_burst = ^HBURST;

    // Below-base addresses wrap to a huge offset, so one compare covers both ends
    assign offset  = HADDR - BASE_ADDR;
    assign aligned = !((HSIZE == HSIZE_HALF && HADDR[0]) ||
                       (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00));
    assign legal   = (HSIZE <= HSIZE_WORD) && aligned && (offset < REGION);

    assign open = (state == ST_IDLE) || (state == ST_DATA) ||
                  (state == ST_ERR2 && HTRANS == HTRANS_NONSEQ);
    assign accept = HSEL && HREADY && HTRANS[1] && open;

`ifdef AHB_MEM_WAIT_EN
    logic [3:0] cnt;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt <= '0;
        end else if (accept && legal) begin
            cnt <= 4'(WAIT_STATES);
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end
`else
    logic unused_ws;
    assign unused_ws = (WAIT_STATES != 0);
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_addr  <= '0;
            a_write <= 1'b0;
            a_size  <= '0;
        end else if (accept) begin
            a_addr  <= offset[MEM_AW+1:0];
            a_write <= HWRITE;
            a_size  <= HSIZE;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) state_nx = legal ? LEGAL_ST : ST_ERR1;
                else        state_nx = ST_IDLE;
            end
`ifdef AHB_MEM_WAIT_EN
            ST_WAIT: if (cnt <= 4'd1) state_nx = ST_DATA;
`endif
            ST_ERR1: state_nx = ST_ERR2;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        case (state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_DATA: if (!a_write) HRDATA = rdata;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // A reset edge that ends a write data phase drops the write
    assign we = (state == ST_DATA && a_write && !HRESET) ?
                byte_en(a_size, a_addr[1:0]) : 4'b0000;

    ahb_mem_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk   (HCLK),
        .addr  (a_addr[MEM_AW+1:2]),
        .we    (we),
        .wdata (HWDATA),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave with a byte-level memory model.
// Honours AHB_MEM_WAIT_EN for the expected wait-cycle count.
module tb_ahb_mem_slave;

    localparam logic [31:0] BASE = 32'h3800_0000;
    localparam int AW = 12;
    localparam int WS = 1;
`ifdef AHB_MEM_WAIT_EN
    localparam int NW = WS;
`else
    localparam int NW = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HADDR = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [2:0]  HBURST = '0;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_mem_slave #(
        .BASE_ADDR   (BASE),
        .MEM_AW      (AW),
        .WAIT_STATES (WS)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit [31:0] addr;
        bit        write;
        bit [2:0]  size;
        bit [31:0] wdata;
    } xfer_t;

    xfer_t       exp_q[$];
    xfer_t       sq[$];
    bit [31:0]   mem_m[int];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = '0;
    int          cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input xfer_t x);
        bit al;
        al = (x.size == 3'd0) ||
             (x.size == 3'd1 && x.addr[0] == 1'b0) ||
             (x.size == 3'd2 && x.addr[1:0] == 2'b00);
        return al && (x.addr >= BASE) && (x.addr <= BASE + (32'd4 << AW) - 32'd1);
    endfunction

    function automatic int widx(input bit [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic void model_write(input xfer_t x);
        int        idx;
        int        o;
        int        n;
        bit [31:0] w;
        idx = widx(x.addr);
        o   = int'(x.addr[1:0]);
        n   = 1 << x.size;
        w   = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int b = o; b < o + n; b++) w[8*b +: 8] = x.wdata[8*b +: 8];
        mem_m[idx] = w;
    endfunction

    function automatic xfer_t mk(input bit w, input bit [31:0] a,
                                 input bit [2:0] s, input bit [31:0] d);
        xfer_t x;
        x.sel   = 1'b1;
        x.trans = 2'b10;
        x.addr  = a;
        x.write = w;
        x.size  = s;
        x.wdata = d;
        return x;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge HCLK);
        while (!HREADYOUT && n < 50) begin
            n++;
            @(negedge HCLK);
        end
        if (!HREADYOUT) chk("ready_timeout", HREADYOUT, 1);
    endtask

    // Drives sq as a pipelined sequence; called and returns at posedge+1
    task automatic run_sq();
        int n;
        n = sq.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                HSEL   = sq[i].sel;
                HTRANS = sq[i].trans;
                HADDR  = sq[i].addr;
                HWRITE = sq[i].write;
                HSIZE  = sq[i].size;
            end else begin
                HSEL   = 1'b1;
                HTRANS = 2'b00;
            end
            wait_ready();
            if (i < n && sq[i].sel && sq[i].trans[1]) exp_q.push_back(sq[i]);
            @(posedge HCLK);
            #1;
            HWDATA = (i < n) ? sq[i].wdata : $urandom;
        end
        sq.delete();
    endtask

    // Monitor: checks every cycle's outputs against the model
    bit    m_pend = 0;
    bit    m_active = 0;
    int    m_waits = 0;
    xfer_t m_cur;
    bit    m_ok;
    int    m_idx;

    initial begin
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                if (m_pend && exp_q.size() > 0) void'(exp_q.pop_front());
                m_pend   = 0;
                m_active = 0;
                continue;
            end
            if (m_pend) begin
                m_pend = 0;
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'(exp_q.size()), 1);
                end else begin
                    m_cur    = exp_q.pop_front();
                    m_active = 1;
                    m_waits  = 0;
                end
            end
            if (m_active) begin
                m_ok = is_legal(m_cur);
                if (!HREADYOUT) begin
                    m_waits++;
                    chk("wait_resp", HRESP, m_ok ? 0 : 1);
                    chk("wait_rdata", HRDATA, 0);
                end else begin
                    chk("wait_count", m_waits, m_ok ? NW : 1);
                    chk("resp", HRESP, m_ok ? 0 : 1);
                    if (m_ok && !m_cur.write) begin
                        m_idx = widx(m_cur.addr);
                        if (mem_m.exists(m_idx)) chk("rdata", HRDATA, mem_m[m_idx]);
                        last_rd = HRDATA;
                    end else begin
                        chk("rdata_zero", HRDATA, 0);
                    end
                    if (m_ok && m_cur.write) model_write(m_cur);
                    m_active = 0;
                end
            end else begin
                chk("idle_ready", HREADYOUT, 1);
                chk("idle_resp", HRESP, 0);
                chk("idle_rdata", HRDATA, 0);
            end
            if (HSEL && HREADYOUT && HTRANS[1]) m_pend = 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t     x;
        int        c0;
        int        kind;
        int        len;
        bit [31:0] a;

        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_ready", HREADYOUT, 1);
        chk("rst_resp", HRESP, 0);
        chk("rst_rdata", HRDATA, 0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        for (int w = 0; w < 16; w++) begin
            sq.push_back(mk(1, BASE + 32'h1000 + 32'(4*w), 3'd2, $urandom));
            sq.push_back(mk(1, BASE + 32'h2000 + 32'(4*w), 3'd2, $urandom));
        end
        run_sq();

        sq.push_back(mk(1, 32'h3800_1000, 3'd2, 32'hDEADBEEF));
        sq.push_back(mk(0, 32'h3800_1000, 3'd2, 32'h0));
        run_sq();
        chk("dir_word_rd", last_rd, 32'hDEADBEEF);

        sq.push_back(mk(1, 32'h3800_1002, 3'd0, 32'h00AA_0000));
        sq.push_back(mk(0, 32'h3800_1000, 3'd2, 32'h0));
        run_sq();
        chk("dir_byte_merge", last_rd, 32'hDEAABEEF);

        sq.push_back(mk(0, 32'h3800_1001, 3'd2, 32'h0));
        sq.push_back(mk(1, 32'h3800_4000, 3'd2, 32'h1111_1111));
        sq.push_back(mk(1, 32'h3800_1000, 3'd3, 32'h2222_2222));
        sq.push_back(mk(0, 32'h37FF_FFFC, 3'd2, 32'h0));
        sq.push_back(mk(1, 32'h3800_1003, 3'd1, 32'h3333_3333));
        sq.push_back(mk(0, 32'h3800_1000, 3'd2, 32'h0));
        run_sq();
        chk("err_ram_kept", last_rd, 32'hDEAABEEF);

        HBURST = 3'b011;
        for (int i = 0; i < 16; i++) begin
            x = mk(1, 32'h3800_2000 + 32'(4*i), 3'd2, 32'(i + 1));
            x.trans = (i == 0) ? 2'b10 : 2'b11;
            sq.push_back(x);
        end
        run_sq();
        for (int i = 0; i < 16; i++) begin
            x = mk(0, 32'h3800_2000 + 32'(4*i), 3'd2, 32'h0);
            x.trans = (i == 0) ? 2'b10 : 2'b11;
            sq.push_back(x);
        end
        c0 = cyc;
        run_sq();
        chk("burst_cycles", 32'(cyc - c0), 32'(1 + 16*(NW + 1)));
        chk("burst_last", last_rd, 32'd16);
        HBURST = 3'b000;

        x = mk(1, 32'h3800_2000, 3'd2, 32'h1234_5678);
        HSEL   = 1'b1;
        HTRANS = x.trans;
        HADDR  = x.addr;
        HWRITE = 1'b1;
        HSIZE  = x.size;
        wait_ready();
        exp_q.push_back(x);
        @(posedge HCLK);
        #1;
        HTRANS = 2'b00;
        HWDATA = x.wdata;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("midrst_ready", HREADYOUT, 1);
        chk("midrst_resp", HRESP, 0);
        chk("midrst_rdata", HRDATA, 0);
        @(posedge HCLK);
        #1;
        sq.push_back(mk(0, 32'h3800_2000, 3'd2, 32'h0));
        run_sq();
        chk("midrst_dropped", last_rd, 32'd1);

        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                kind = $urandom_range(0, 11);
                a = BASE + ($urandom_range(0, 1) ? 32'h1000 : 32'h2000) +
                    32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                x = mk($urandom_range(0, 1), a, 3'($urandom_range(0, 3)), $urandom);
                if (kind == 0) x.sel = 1'b0;
                if (kind == 1) x.trans = $urandom_range(0, 1) ? 2'b01 : 2'b00;
                if (kind == 2) x.addr = $urandom_range(0, 1) ?
                                        32'h3800_4000 + 32'($urandom_range(0, 255) * 4) :
                                        32'h37FF_FF00 + 32'($urandom_range(0, 63) * 4);
                if (kind >= 3 && kind <= 6) x.addr[1:0] = 2'b00;
                sq.push_back(x);
            end
            run_sq();
        end

        repeat (3) @(posedge HCLK);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
